// File: rtl/mrv32_pkg.sv
// mrv32_pkg: shared types and constants for the mrv32 decode stage.
//   instr_class_t - 4-bit instruction class, CL_ILLEGAL = 0
//   OPC_*         - RV32I major opcodes (instr[6:0])
//   dec_bundle_t  - decoded bundle handed from decode to execute
//   dec_state_t   - decode holding-register occupancy
package mrv32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 7;

  typedef enum logic [3:0] {
    CL_ILLEGAL = 4'd0,
    CL_LUI     = 4'd1,
    CL_AUIPC   = 4'd2,
    CL_JAL     = 4'd3,
    CL_JALR    = 4'd4,
    CL_BRANCH  = 4'd5,
    CL_LOAD    = 4'd6,
    CL_STORE   = 4'd7,
    CL_OPIMM   = 4'd8,
    CL_OP      = 4'd9,
    CL_FENCE   = 4'd10,
    CL_SYSTEM  = 4'd11
  } instr_class_t;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    instr_class_t      cls;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   imm;
    logic              rs1_en;
    logic              rs2_en;
    logic              rd_we;
    logic              illegal;
  } dec_bundle_t;

  typedef enum logic {
    DEC_EMPTY = 1'b0,
    DEC_FULL  = 1'b1
  } dec_state_t;

endpackage

// File: rtl/mrv32_imm_gen.sv
// mrv32_imm_gen: combinational RV32I immediate extraction, selected by class.
//   i_instr  - instruction word
//   i_cls    - decoded instruction class
//   o_imm_c  - sign-extended immediate (0 for OP/FENCE/ILLEGAL)
module mrv32_imm_gen
  import mrv32_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  input  instr_class_t    i_cls,
  output logic [XLEN-1:0] o_imm_c
);

  logic w_s;
  assign w_s = i_instr[31];

  // Format select; SYSTEM uses the I-format (CSR address field)
  always_comb begin
    o_imm_c = '0;
    case (i_cls)
      CL_JALR, CL_LOAD, CL_OPIMM, CL_SYSTEM:
        o_imm_c = {{20{w_s}}, i_instr[31:20]};
      CL_STORE:
        o_imm_c = {{20{w_s}}, i_instr[31:25], i_instr[11:7]};
      CL_BRANCH:
        o_imm_c = {{19{w_s}}, w_s, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      CL_LUI, CL_AUIPC:
        o_imm_c = {i_instr[31:12], 12'b0};
      CL_JAL:
        o_imm_c = {{11{w_s}}, w_s, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default:
        o_imm_c = '0;
    endcase
  end

endmodule

// File: rtl/mrv32_decode.sv
// mrv32_decode: RV32I decode stage with a one-entry output holding register.
//   clk, rst_n          - clock, async active-low reset
//   instr, pc           - fetched word and its PC, valid only with instr_valid
//   instr_valid         - single-cycle fetch pulse
//   flush               - drop held and same-cycle incoming instruction
//   d_valid / d_ready   - handshake to execute
//   d_pc .. d_illegal   - registered decoded bundle
//   ovf_err             - sticky: pulse arrived while full and not draining
module mrv32_decode
  import mrv32_pkg::*;
#(
  parameter bit ILLEGAL_ZERO = 1'b1,
  parameter bit EN_SYSTEM    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   instr,
  input  logic [XLEN-1:0]   pc,
  input  logic              instr_valid,
  input  logic              flush,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [XLEN-1:0]   d_pc,
  output logic [3:0]        d_class,
  output logic [2:0]        d_funct3,
  output logic              d_funct7b5,
  output logic [REG_AW-1:0] d_rd,
  output logic [REG_AW-1:0] d_rs1,
  output logic [REG_AW-1:0] d_rs2,
  output logic [XLEN-1:0]   d_imm,
  output logic              d_rs1_en,
  output logic              d_rs2_en,
  output logic              d_rd_we,
  output logic              d_illegal,
  output logic              ovf_err
);

  dec_state_t   r_state;
  dec_state_t   w_state_nxt;
  dec_bundle_t  r_bundle;
  dec_bundle_t  w_bundle;
  logic         r_ovf;
  logic         w_capture;
  logic         w_ovf_set;

  logic [OPC_W-1:0] w_opcode;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [REG_AW-1:0] w_rd;
  instr_class_t     w_cls;
  logic             w_bad;
  logic [XLEN-1:0]  w_imm;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_rd     = instr[11:7];

  // Class lookup plus per-opcode encoding legality; illegal collapses to CL_ILLEGAL
  always_comb begin
    w_cls = CL_ILLEGAL;
    w_bad = 1'b0;
    case (w_opcode)
      OPC_LUI:    w_cls = CL_LUI;
      OPC_AUIPC:  w_cls = CL_AUIPC;
      OPC_JAL:    w_cls = CL_JAL;
      OPC_JALR: begin
        w_cls = CL_JALR;
        w_bad = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_cls = CL_BRANCH;
        w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_LOAD: begin
        w_cls = CL_LOAD;
        w_bad = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        w_cls = CL_STORE;
        w_bad = (w_f3 > 3'b010);
      end
      OPC_OPIMM: begin
        w_cls = CL_OPIMM;
        w_bad = ((w_f3 == 3'b001) && (w_f7 != 7'b0000000)) ||
                ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000));
      end
      OPC_OP: begin
        w_cls = CL_OP;
        w_bad = ((w_f7 != 7'b0000000) && (w_f7 != 7'b0100000)) ||
                ((w_f7 == 7'b0100000) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
      end
      OPC_FENCE:  w_cls = CL_FENCE;
      OPC_SYSTEM: if (EN_SYSTEM) w_cls = CL_SYSTEM;
      default:    w_cls = CL_ILLEGAL;
    endcase
    if (instr[1:0] != 2'b11) w_bad = 1'b1;
    if (ILLEGAL_ZERO && (instr == '0)) w_bad = 1'b1;
    if (w_bad) w_cls = CL_ILLEGAL;
  end

  mrv32_imm_gen u_imm_gen (
    .i_instr (instr),
    .i_cls   (w_cls),
    .o_imm_c (w_imm)
  );

  // Assemble the bundle; enables derive from the final (post-legality) class
  always_comb begin
    w_bundle          = '0;
    w_bundle.pc       = pc;
    w_bundle.cls      = w_cls;
    w_bundle.funct3   = w_f3;
    w_bundle.funct7b5 = instr[30];
    w_bundle.rd       = w_rd;
    w_bundle.rs1      = instr[19:15];
    w_bundle.rs2      = instr[24:20];
    w_bundle.imm      = w_imm;
    w_bundle.illegal  = (w_cls == CL_ILLEGAL);
    case (w_cls)
      CL_LUI, CL_AUIPC, CL_JAL: begin
        w_bundle.rd_we = (w_rd != '0);
      end
      CL_JALR, CL_LOAD, CL_OPIMM: begin
        w_bundle.rs1_en = 1'b1;
        w_bundle.rd_we  = (w_rd != '0);
      end
      CL_BRANCH, CL_STORE: begin
        w_bundle.rs1_en = 1'b1;
        w_bundle.rs2_en = 1'b1;
      end
      CL_OP: begin
        w_bundle.rs1_en = 1'b1;
        w_bundle.rs2_en = 1'b1;
        w_bundle.rd_we  = (w_rd != '0);
      end
      default: ;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DEC_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state, capture strobe and overflow detect; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ovf_set   = 1'b0;
    if (flush) begin
      w_state_nxt = DEC_EMPTY;
    end else begin
      case (r_state)
        DEC_EMPTY: begin
          if (instr_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = DEC_FULL;
          end
        end
        DEC_FULL: begin
          if (d_ready) begin
            if (instr_valid) w_capture   = 1'b1;
            else             w_state_nxt = DEC_EMPTY;
          end else if (instr_valid) begin
            w_ovf_set = 1'b1;
          end
        end
        default: w_state_nxt = DEC_EMPTY;
      endcase
    end
  end

  // Bundle holding register and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bundle <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_capture) r_bundle <= w_bundle;
      if (w_ovf_set) r_ovf    <= 1'b1;
    end
  end

  assign d_valid    = (r_state == DEC_FULL);
  assign d_pc       = r_bundle.pc;
  assign d_class    = r_bundle.cls;
  assign d_funct3   = r_bundle.funct3;
  assign d_funct7b5 = r_bundle.funct7b5;
  assign d_rd       = r_bundle.rd;
  assign d_rs1      = r_bundle.rs1;
  assign d_rs2      = r_bundle.rs2;
  assign d_imm      = r_bundle.imm;
  assign d_rs1_en   = r_bundle.rs1_en;
  assign d_rs2_en   = r_bundle.rs2_en;
  assign d_rd_we    = r_bundle.rd_we;
  assign d_illegal  = r_bundle.illegal;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_mrv32_decode.sv
// tb_mrv32_decode: directed bench for mrv32_decode with a queue-based reference model.
module tb_mrv32_decode;
  import mrv32_pkg::*;

  localparam bit ILZ = 1'b1;
  localparam bit ENS = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        d_ready = 1'b0;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [3:0]  d_class;
  logic [2:0]  d_funct3;
  logic        d_funct7b5;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm;
  logic        d_rs1_en, d_rs2_en, d_rd_we, d_illegal, ovf_err;

  int n_vec = 0;
  int n_err = 0;

  mrv32_decode #(.ILLEGAL_ZERO(ILZ), .EN_SYSTEM(ENS)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc), .instr_valid(instr_valid),
    .flush(flush), .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc),
    .d_class(d_class), .d_funct3(d_funct3), .d_funct7b5(d_funct7b5), .d_rd(d_rd),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_imm(d_imm), .d_rs1_en(d_rs1_en),
    .d_rs2_en(d_rs2_en), .d_rd_we(d_rd_we), .d_illegal(d_illegal), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the ISA tables
  function automatic dec_bundle_t model_dec(input logic [31:0] w, input logic [31:0] p);
    dec_bundle_t      b;
    logic [6:0]       op;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             ok;
    instr_class_t     c;
    logic signed [11:0] iimm;
    logic signed [11:0] simm;
    logic signed [12:0] bimm;
    logic signed [20:0] jimm;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    iimm = w[31:20];
    simm = {w[31:25], w[11:7]};
    bimm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    jimm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    b = '0;
    b.pc = p; b.funct3 = f3; b.funct7b5 = w[30];
    b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
    ok = 1'b1;
    c = CL_ILLEGAL;
    case (op)
      7'b0110111: begin c = CL_LUI;    b.imm = w & 32'hFFFFF000; end
      7'b0010111: begin c = CL_AUIPC;  b.imm = w & 32'hFFFFF000; end
      7'b1101111: begin c = CL_JAL;    b.imm = 32'(jimm); end
      7'b1100111: begin c = CL_JALR;   b.imm = 32'(iimm); ok = (f3 == 0); end
      7'b1100011: begin c = CL_BRANCH; b.imm = 32'(bimm); ok = !(f3 inside {3'd2, 3'd3}); end
      7'b0000011: begin c = CL_LOAD;   b.imm = 32'(iimm); ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      7'b0100011: begin c = CL_STORE;  b.imm = 32'(simm); ok = (f3 <= 3'd2); end
      7'b0010011: begin
        c = CL_OPIMM; b.imm = 32'(iimm);
        ok = !((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})));
      end
      7'b0110011: begin
        c = CL_OP;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 inside {3'd0, 3'd5}));
      end
      7'b0001111: c = CL_FENCE;
      7'b1110011: begin c = ENS ? CL_SYSTEM : CL_ILLEGAL; b.imm = 32'(iimm); end
      default:    c = CL_ILLEGAL;
    endcase
    if (!ok || c == CL_ILLEGAL || (ILZ && w == 32'h0)) begin
      b.cls = CL_ILLEGAL; b.illegal = 1'b1; b.imm = '0;
      return b;
    end
    b.cls    = c;
    b.rs1_en = c inside {CL_JALR, CL_BRANCH, CL_LOAD, CL_STORE, CL_OPIMM, CL_OP};
    b.rs2_en = c inside {CL_BRANCH, CL_STORE, CL_OP};
    b.rd_we  = (c inside {CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_LOAD, CL_OPIMM, CL_OP}) && (w[11:7] != 0);
    return b;
  endfunction

  // One-deep queue model of the holding register
  dec_bundle_t m_q[$];
  logic        m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && d_ready) void'(m_q.pop_front());
      if (instr_valid) begin
        if (m_q.size() == 0) m_q.push_back(model_dec(instr, pc));
        else                 m_ovf = 1'b1;
      end
    end
  end

  dec_bundle_t dut_b;
  always_comb begin
    dut_b          = '0;
    dut_b.pc       = d_pc;
    dut_b.cls      = instr_class_t'(d_class);
    dut_b.funct3   = d_funct3;
    dut_b.funct7b5 = d_funct7b5;
    dut_b.rd       = d_rd;
    dut_b.rs1      = d_rs1;
    dut_b.rs2      = d_rs2;
    dut_b.imm      = d_imm;
    dut_b.rs1_en   = d_rs1_en;
    dut_b.rs2_en   = d_rs2_en;
    dut_b.rd_we    = d_rd_we;
    dut_b.illegal  = d_illegal;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_d_valid", 128'(d_valid), 128'(m_q.size() != 0));
      chk("cyc_ovf_err", 128'(ovf_err), 128'(m_ovf));
      if (m_q.size() != 0) chk("cyc_bundle", 128'(dut_b), 128'(m_q[0]));
    end
  end

  task automatic pulse(input logic [31:0] w, input logic [31:0] p);
    @(negedge clk);
    instr = w; pc = p; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  logic [31:0] tbl [12] = '{
    32'h008000EF, 32'h00008067, 32'h00001197, 32'h00412203,
    32'h00000073, 32'h0FF0000F, 32'h407352B3, 32'h4030D093,
    32'h00009067, 32'h0000B003, 32'h02009093, 32'h00100013
  };

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_d_valid", 128'(d_valid), 128'(0));
    chk("rst_ovf", 128'(ovf_err), 128'(0));
    chk("rst_class", 128'(d_class), 128'(0));
    chk("rst_imm", 128'(d_imm), 128'(0));
    chk("rst_pc", 128'(d_pc), 128'(0));
    rst_n = 1'b1;
    d_ready = 1'b1;

    // addi x1,x0,5
    pulse(32'h00500093, 32'h100);
    chk("addi_valid", 128'(d_valid), 128'(1));
    chk("addi_class", 128'(d_class), 128'(CL_OPIMM));
    chk("addi_rd", 128'(d_rd), 128'(1));
    chk("addi_rs1", 128'(d_rs1), 128'(0));
    chk("addi_imm", 128'(d_imm), 128'(5));
    chk("addi_en", 128'({d_rd_we, d_rs1_en, d_rs2_en}), 128'(3'b110));
    chk("addi_pc", 128'(d_pc), 128'(32'h100));

    pulse(32'h0020A423, 32'h104);
    chk("sw_class", 128'(d_class), 128'(CL_STORE));
    chk("sw_imm", 128'(d_imm), 128'(8));
    chk("sw_en", 128'({d_rs2_en, d_rd_we}), 128'(2'b10));

    pulse(32'hFE000EE3, 32'h108);
    chk("beq_class", 128'(d_class), 128'(CL_BRANCH));
    chk("beq_imm", 128'(d_imm), 128'(32'hFFFFFFFC));

    pulse(32'h123452B7, 32'h10C);
    chk("lui_imm", 128'(d_imm), 128'(32'h12345000));
    chk("lui_rd", 128'(d_rd), 128'(5));

    // illegal encodings
    pulse(32'hFFFFFFFF, 32'h110);
    chk("ill_ff", 128'({d_illegal, d_class, d_rs1_en, d_rs2_en, d_rd_we}), 128'({1'b1, 4'd0, 3'b000}));
    pulse(32'h00000000, 32'h114);
    chk("ill_zero", 128'({d_illegal, d_class}), 128'({1'b1, 4'd0}));
    pulse(32'h40001033, 32'h118);
    chk("ill_op", 128'({d_illegal, d_class, d_rs1_en, d_rs2_en, d_rd_we}), 128'({1'b1, 4'd0, 3'b000}));

    // mixed classes, checked by the per-cycle model compare
    for (int i = 0; i < 12; i++) begin
      pulse(tbl[i], 32'h1000 + 32'(i * 4));
      @(negedge clk);
    end

    // backpressure
    d_ready = 1'b0;
    pulse(32'h00500093, 32'h200);
    chk("bp_valid", 128'(d_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 128'({d_valid, d_pc, d_imm}), 128'({1'b1, 32'h200, 32'h5}));
    end
    pulse(32'h123452B7, 32'h204);
    chk("bp_ovf", 128'(ovf_err), 128'(1));
    chk("bp_keep", 128'({d_pc, d_imm}), 128'({32'h200, 32'h5}));
    @(negedge clk);
    d_ready = 1'b1; instr = 32'hFE000EE3; pc = 32'h208; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b_valid", 128'(d_valid), 128'(1));
    chk("b2b_bundle", 128'({d_pc, d_class, d_imm}), 128'({32'h208, CL_BRANCH, 32'hFFFFFFFC}));

    // flush with concurrent pulse
    d_ready = 1'b0;
    pulse(32'h00500093, 32'h300);
    @(negedge clk);
    flush = 1'b1; instr = 32'h0020A423; pc = 32'h304; instr_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; instr_valid = 1'b0;
    chk("flush_valid", 128'(d_valid), 128'(0));
    chk("flush_ovf", 128'(ovf_err), 128'(1));
    pulse(32'h0020A423, 32'h308);
    chk("post_flush", 128'({d_valid, d_pc, d_class}), 128'({1'b1, 32'h308, CL_STORE}));

    // async reset while full
    pulse(32'h123452B7, 32'h30C);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(d_valid), 128'(0));
    chk("async_rst_ovf", 128'(ovf_err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    d_ready = 1'b1;
    pulse(32'h00500093, 32'h400);
    chk("after_rst", 128'({d_valid, d_pc}), 128'({1'b1, 32'h400}));
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
